// File: rtl/fan_pid_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fan_pid_sequencer                                            |
// | Description : Velocity-form PID sequencer for the fan controller. Divides  |
// |               the clock into a sample tick, forms the speed error, runs    |
// |               three req/done transactions on a shared coefficient MAC and  |
// |               scales/saturates the result into pid_out.                    |
// |               Optional: define PID_DEADBAND_EN to zero small errors.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fan_pid_sequencer #(
    parameter int ADC_BITWIDTH = 4,
    parameter int CLK_DIV      = 199999,
    parameter int ACC_W        = 16,
    parameter int FRAC_BITS    = 8,
    parameter int MAC_TIMEOUT  = 15,
    parameter int DEADBAND     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [ADC_BITWIDTH-1:0]        adc_val,
    input  logic [ADC_BITWIDTH-1:0]        set_val,
    output logic                           mac_req,
    output logic [1:0]                     mac_sel,
    output logic                           mac_clr,
    output logic signed [ADC_BITWIDTH:0]   mac_operand,
    input  logic                           mac_done,
    input  logic signed [ACC_W-1:0]        mac_result,
    output logic signed [ADC_BITWIDTH:0]   pid_out,
    output logic                           pid_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic                           mac_fault
);

    localparam int c_OUT_W  = ADC_BITWIDTH + 1;
    localparam int c_CNT_W  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int c_WCNT_W = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0]         c_DIV_MAX   = c_CNT_W'(CLK_DIV);
    localparam logic [c_WCNT_W-1:0]        c_WAIT_LAST = c_WCNT_W'(MAC_TIMEOUT - 1);
    localparam logic signed [ACC_W:0]      c_SUM_MAX   = (ACC_W + 1)'((1 << ADC_BITWIDTH) - 1);
    localparam logic signed [c_OUT_W-1:0]  c_PID_MAX   = c_OUT_W'((1 << ADC_BITWIDTH) - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CAPTURE = 3'd1;
    localparam logic [2:0] c_ST_ISSUE   = 3'd2;
    localparam logic [2:0] c_ST_WAIT    = 3'd3;
    localparam logic [2:0] c_ST_UPDATE  = 3'd4;

    logic [c_CNT_W-1:0]         r_cnt;
    logic [2:0]                 r_state;
    logic [1:0]                 r_step;
    logic [c_WCNT_W-1:0]        r_wait_cnt;
    logic signed [c_OUT_W-1:0]  r_e0;
    logic signed [c_OUT_W-1:0]  r_e1;
    logic signed [c_OUT_W-1:0]  r_e2;
    logic signed [c_OUT_W-1:0]  r_u_prev;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_tick;
    logic signed [c_OUT_W-1:0]  w_e0_raw;
    logic signed [c_OUT_W-1:0]  w_e0;
    logic signed [c_OUT_W-1:0]  w_operand;
    logic signed [ACC_W:0]      w_acc_ext;
    logic signed [ACC_W:0]      w_acc_shift;
    logic signed [ACC_W:0]      w_uprev_ext;
    logic signed [ACC_W:0]      w_sum;
    logic signed [c_OUT_W-1:0]  w_sat;

    assign w_tick   = ena && (r_cnt == c_DIV_MAX);
    assign w_e0_raw = $signed({1'b0, set_val}) - $signed({1'b0, adc_val});

`ifdef PID_DEADBAND_EN
    localparam logic signed [c_OUT_W-1:0] c_DB = c_OUT_W'(DEADBAND);
    assign w_e0 = ((w_e0_raw <= c_DB) && (w_e0_raw >= -c_DB)) ? '0 : w_e0_raw;
`else
    logic w_unused_deadband;
    assign w_unused_deadband = (DEADBAND != 0);
    assign w_e0 = w_e0_raw;
`endif

    // Operand for the coefficient currently being issued: e0, e1, e2 in order
    always_comb begin
        w_operand = r_e0;
        case (r_step)
            2'd1:    w_operand = r_e1;
            2'd2:    w_operand = r_e2;
            default: w_operand = r_e0;
        endcase
    end

    // Drop the fractional bits of the MAC sum and add the previous output
    assign w_acc_ext   = {r_acc[ACC_W-1], r_acc};
    assign w_acc_shift = w_acc_ext >>> FRAC_BITS;
    assign w_uprev_ext = {{(ACC_W - ADC_BITWIDTH){r_u_prev[c_OUT_W-1]}}, r_u_prev};
    assign w_sum       = w_uprev_ext + w_acc_shift;

    // Clamp to the PWM range; storing the clamped value as u_prev stops windup
    always_comb begin
        w_sat = w_sum[c_OUT_W-1:0];
        if (w_sum[ACC_W])
            w_sat = '0;
        else if (w_sum > c_SUM_MAX)
            w_sat = c_PID_MAX;
    end

    // Sample-rate divider; frozen while the design is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (ena)
            r_cnt <= (r_cnt == c_DIV_MAX) ? '0 : r_cnt + 1'b1;
    end

    // Sequencer: capture error, three MAC transactions, then output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_step      <= 2'd0;
            r_wait_cnt  <= '0;
            r_e0        <= '0;
            r_e1        <= '0;
            r_e2        <= '0;
            r_u_prev    <= '0;
            r_acc       <= '0;
            mac_req     <= 1'b0;
            mac_sel     <= 2'd0;
            mac_clr     <= 1'b0;
            mac_operand <= '0;
            pid_out     <= '0;
            pid_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            mac_fault   <= 1'b0;
        end else begin
            pid_valid <= 1'b0;
            // Any tick outside IDLE (UPDATE included) is dropped and flagged
            if (w_tick && (r_state != c_ST_IDLE))
                overrun <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick)
                        r_state <= c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    r_e0    <= w_e0;
                    busy    <= 1'b1;
                    r_step  <= 2'd0;
                    r_state <= c_ST_ISSUE;
                end
                c_ST_ISSUE: begin
                    mac_req     <= 1'b1;
                    mac_sel     <= r_step;
                    mac_clr     <= (r_step == 2'd0);
                    mac_operand <= w_operand;
                    r_wait_cnt  <= '0;
                    r_state     <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (mac_done) begin
                        mac_req <= 1'b0;
                        r_acc   <= mac_result;
                        if (r_step == 2'd2) begin
                            r_state <= c_ST_UPDATE;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= c_ST_ISSUE;
                        end
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        // MAC unresponsive: abandon the sample, keep history
                        mac_req   <= 1'b0;
                        mac_fault <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_ST_UPDATE: begin
                    pid_out   <= w_sat;
                    r_u_prev  <= w_sat;
                    r_e2      <= r_e1;
                    r_e1      <= r_e0;
                    pid_valid <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fan_pid_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fan_pid_sequencer                                         |
// | Description : Directed self-checking bench for fan_pid_sequencer with a    |
// |               behavioural coefficient MAC (CLK_DIV=9).                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fan_pid_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [3:0]        adc_val;
    logic [3:0]        set_val;
    logic              mac_req;
    logic [1:0]        mac_sel;
    logic              mac_clr;
    logic signed [4:0] mac_operand;
    logic              mac_done = 1'b0;
    logic signed [15:0] mac_result = '0;
    logic signed [4:0] pid_out;
    logic              pid_valid;
    logic              busy;
    logic              overrun;
    logic              mac_fault;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int rise_q[$];
    int op_q[$];
    int sel_q[$];
    int clr_q[$];
    int hi_q[$];
    int pv_q[$];
    int pvv_q[$];
    logic req_d = 1'b0;

    int k0, k1, k2, k_sel;
    int done_delay;
    bit never_done;
    int req_cnt = 0;
    logic signed [15:0] acc_m = '0;

    fan_pid_sequencer #(
        .ADC_BITWIDTH (4),
        .CLK_DIV      (9),
        .ACC_W        (16),
        .FRAC_BITS    (8),
        .MAC_TIMEOUT  (15),
        .DEADBAND     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .adc_val     (adc_val),
        .set_val     (set_val),
        .mac_req     (mac_req),
        .mac_sel     (mac_sel),
        .mac_clr     (mac_clr),
        .mac_operand (mac_operand),
        .mac_done    (mac_done),
        .mac_result  (mac_result),
        .pid_out     (pid_out),
        .pid_valid   (pid_valid),
        .busy        (busy),
        .overrun     (overrun),
        .mac_fault   (mac_fault)
    );

    always #5 clk = ~clk;

    // Edge counter: cyc = number of rising edges since reset release
    always @(posedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // MAC model: answers done_delay cycles after req is seen, valid for one edge
    always @(negedge clk) begin
        mac_done = 1'b0;
        if (!rst_n || !mac_req) begin
            req_cnt = 0;
        end else if (!never_done) begin
            if (req_cnt >= done_delay) begin
                case (mac_sel)
                    2'd0:    k_sel = k0;
                    2'd1:    k_sel = k1;
                    default: k_sel = k2;
                endcase
                if (mac_clr) acc_m = 16'(k_sel * int'(mac_operand));
                else         acc_m = acc_m + 16'(k_sel * int'(mac_operand));
                mac_result = acc_m;
                mac_done   = 1'b1;
                req_cnt    = 0;
            end else begin
                req_cnt = req_cnt + 1;
            end
        end
    end

    // Event log of request rises, request-high cycles and pid_valid pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            rise_q.delete(); op_q.delete(); sel_q.delete(); clr_q.delete();
            hi_q.delete(); pv_q.delete(); pvv_q.delete();
            req_d = 1'b0;
        end else begin
            if (mac_req && !req_d) begin
                rise_q.push_back(cyc);
                op_q.push_back(int'(mac_operand));
                sel_q.push_back(int'(mac_sel));
                clr_q.push_back(int'(mac_clr));
            end
            if (mac_req) hi_q.push_back(cyc);
            if (pid_valid) begin
                pv_q.push_back(cyc);
                pvv_q.push_back(int'(pid_out));
            end
            req_d = mac_req;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    function automatic int count_range(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    initial begin
        rst_n = 1'b0; ena = 1'b0; adc_val = 4'd7; set_val = 4'd12;
        k0 = 256; k1 = 0; k2 = 0; done_delay = 0; never_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mac_req",   int'(mac_req), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_pid_out",   int'(pid_out), 0);
        chk("rst_pid_valid", int'(pid_valid), 0);
        chk("rst_flags",     int'({overrun, mac_fault}), 0);
        chk("rst_mac_bus",   int'({mac_sel, mac_clr, mac_operand}), 0);

        // Disabled: no ticks; enabling resumes from the held counter
        rst_n = 1'b1;
        run_to(30);
        chk("ena0_no_req", rise_q.size(), 0);
        ena = 1'b1;
        run_to(43);
        chk("ena1_first_req", rise_q[0], 42);

        // Integration with K0=256, e=5
        do_reset();
        run_to(49);
        chk("int_req0_edge", rise_q[0], 12);
        chk("int_req1_edge", rise_q[1], 14);
        chk("int_req2_edge", rise_q[2], 16);
        chk("int_pv_count",  pv_q.size(), 4);
        chk("int_pv0_edge",  pv_q[0], 18);
        chk("int_pv3_edge",  pv_q[3], 48);
        chk("int_pid0", pvv_q[0], 5);
        chk("int_pid1", pvv_q[1], 10);
        chk("int_pid2", pvv_q[2], 15);
        chk("int_pid3_sat", pvv_q[3], 15);
        chk("int_op0",  op_q[0], 5);
        chk("int_clr0", clr_q[0], 1);
        chk("int_clr1", clr_q[1], 0);
        chk("int_sel2", sel_q[2], 2);

        // Negative error clamps at 0
        adc_val = 4'd12; set_val = 4'd5;
        do_reset();
        run_to(29);
        chk("neg_op0",  op_q[0], -7);
        chk("neg_pid0", pvv_q[0], 0);
        chk("neg_pid1", pvv_q[1], 0);

        // History: only K1 nonzero, constant e=3
        adc_val = 4'd4; set_val = 4'd7; k0 = 0; k1 = 256;
        do_reset();
        run_to(39);
        chk("hist_pid0", pvv_q[0], 0);
        chk("hist_pid1", pvv_q[1], 3);
        chk("hist_pid2", pvv_q[2], 6);
        chk("hist_s1_e1", op_q[4], 3);
        chk("hist_s1_e2", op_q[5], 0);
        chk("hist_s2_e2", op_q[8], 3);

        // Slow MAC: ticks arrive while busy
        adc_val = 4'd7; set_val = 4'd12; k0 = 256; k1 = 0; done_delay = 12;
        do_reset();
        run_to(58);
        chk("ovr_flag",      int'(overrun), 1);
        chk("ovr_req_count", rise_q.size(), 3);
        chk("ovr_req1_edge", rise_q[1], 26);
        chk("ovr_pv_count",  pv_q.size(), 1);
        chk("ovr_pv_edge",   pv_q[0], 54);
        chk("ovr_pid",       pvv_q[0], 5);

        // Timeout: MAC goes silent after one good sample
        done_delay = 0;
        do_reset();
        run_to(19);
        chk("to_pid_before", pvv_q[0], 5);
        never_done = 1'b1;
        run_to(39);
        chk("to_req_high_cycles", count_range(hi_q, 20, 39), 15);
        chk("to_fault",    int'(mac_fault), 1);
        chk("to_pid_kept", int'(pid_out), 5);
        chk("to_no_pv",    pv_q.size(), 1);
        chk("to_idle",     int'({busy, mac_req}), 0);

        // Asynchronous reset while waiting on the MAC
        run_to(44);
        chk("arst_req_before", int'(mac_req), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_mac_req", int'(mac_req), 0);
        chk("arst_busy",    int'(busy), 0);
        chk("arst_pid_out", int'(pid_out), 0);
        chk("arst_fault",   int'(mac_fault), 0);

        // Small error: zeroed by the deadband option, raw otherwise
        never_done = 1'b0; adc_val = 4'd6; set_val = 4'd7;
        do_reset();
        run_to(13);
`ifdef PID_DEADBAND_EN
        chk("db_op0", op_q[0], 0);
`else
        chk("raw_op0", op_q[0], 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fan_pid_sequencer.md
Name: fan_pid_sequencer

Overview:
Sequences one velocity-form PID update per control sample for the fan controller: u[n] = u[n-1] + K0·e[n] + K1·e[n-1] + K2·e[n-2].
- Divides the 1 MHz clock into a sample tick.
- Latches the ADC and setpoint nibbles and forms the error.
- Drives a shared external coefficient MAC through three req/done transactions.
- Scales, saturates and registers the PID output that feeds the PWM and 7-segment stages.
- Coefficients live in the MAC; this block only sequences it.

Parameters:
- ADC_BITWIDTH, 4, width of adc_val/set_val; pid_out is ADC_BITWIDTH+1 signed.
- CLK_DIV, 199999, sample period minus 1 in clk cycles (5 Hz at 1 MHz).
- ACC_W, 16, signed MAC accumulator width.
- FRAC_BITS, 8, fractional bits of MAC result.
- MAC_TIMEOUT, 15, max cycles mac_req may stay high without mac_done.
- DEADBAND, 1, error magnitude zeroed when PID_DEADBAND_EN is defined.

Ports:
- clk  in  1  system clock, 1 MHz
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable
- adc_val  in  ADC_BITWIDTH  measured fan speed
- set_val  in  ADC_BITWIDTH  setpoint
- mac_req  out  1  MAC operation request
- mac_sel  out  2  coefficient select: 0=K0, 1=K1, 2=K2
- mac_clr  out  1  high with sel 0: accumulator loads the product instead of adding it
- mac_operand  out  ADC_BITWIDTH+1  signed error operand
- mac_done  in  1  single-cycle completion strobe
- mac_result  in  ACC_W  signed accumulated sum, valid with mac_done
- pid_out  out  ADC_BITWIDTH+1  signed PID output, always in 0..2^ADC_BITWIDTH-1
- pid_valid  out  1  one-cycle pulse on pid_out update
- busy  out  1  sequence in progress
- overrun  out  1  sticky: tick arrived while busy
- mac_fault  out  1  sticky: MAC timeout

Behaviour:
- Reset (async): all outputs 0; counter, error history e1/e2, u_prev and state cleared; state IDLE.
- Divider:
  - Counter counts 0..CLK_DIV, then wraps to 0.
  - tick = (counter==CLK_DIV).
  - ena=0: counter holds and no ticks; an in-progress sequence completes.
- tick while busy: tick dropped, overrun<=1.
- FSM: IDLE -> CAPTURE -> ISSUE(t) -> WAIT(t) -> ... -> UPDATE -> IDLE, with t=0,1,2.
- CAPTURE (edge after tick):
  - Registers e0 = set_val - adc_val in ADC_BITWIDTH+1 signed.
  - busy<=1.
- ISSUE (t):
  - mac_req<=1, mac_sel<=t, mac_clr<=(t==0).
  - mac_operand <= e0 / e1 / e2 for t = 0 / 1 / 2.
- WAIT:
  - Outputs held stable while mac_req=1.
  - mac_done sampled high: mac_req<=0; next state ISSUE(t+1), or UPDATE after t=2.
  - mac_req is low at least one cycle between operations.
  - mac_done while mac_req=0 is ignored.
- Timeout:
  - Cycles in WAIT are counted.
  - When the count reaches MAC_TIMEOUT: mac_req<=0, mac_fault<=1, sequence aborted.
  - On abort: no pid_valid; pid_out and history unchanged; busy<=0; return to IDLE.
- UPDATE:
  - sum = u_prev + (mac_result >>> FRAC_BITS), arithmetic shift, computed in ACC_W+1 bits.
  - Saturate to [0, 2^ADC_BITWIDTH-1].
  - pid_out<=sat, u_prev<=sat (inherent anti-windup).
  - e2<=e1, e1<=e0; pid_valid<=1 for one cycle; busy<=0.
- Latency (MAC asserting done one cycle after seeing req):
  - tick at edge k: mac_req high at k+2, k+4, k+6.
  - pid_valid at edge k+8.
- Ticks are checked in IDLE and UPDATE. A tick in UPDATE counts as busy -> overrun.

Optional Feature:
- PID_DEADBAND_EN defined: in CAPTURE, if |e0| <= DEADBAND then e0 is stored as 0.
- Not defined: e0 is the raw difference; the DEADBAND parameter is unused.

Test Plan:
- Reset + idle: hold rst_n=0 -> all outputs 0. Release with CLK_DIV=9, ena=1 -> a tick every 10 cycles and mac_req pattern at k+2/k+4/k+6. With ena=0 -> no mac_req.
- Integration: adc=7, set=12, model K0=256, K1=K2=0 -> pid_out 5, 10, 15, 15 (saturated) on successive pid_valid pulses, each 8 cycles after its tick.
- Negative clamp: adc=12, set=5, same model -> pid_out stays 0; mac_operand = -7 (5'b11001).
- History: K0=0, K1=256, K2=0, e=3 constant -> first pid_out 0, then 3, 6. mac_operand order per sample is e0, e1, e2.
- Overrun/timeout:
  - Model delays done by 12 cycles with CLK_DIV=9 -> overrun=1, dropped tick causes no extra capture.
  - Model never asserts done -> mac_req drops after 15 cycles, mac_fault=1, pid_out unchanged, no pid_valid.
- Reset mid-WAIT: rst_n low while mac_req=1 -> mac_req, busy, pid_out go 0 immediately without a clock edge. With PID_DEADBAND_EN, adc=6, set=7 -> mac_operand 0.
